booth_div_signed_iter: RTL and testbench

Iterative signed integer divider, the inverse datapath to the team's radix-4 Booth signed multiplier: takes a two's-complement dividend and divisor of `width` bits and produces a truncated-toward-zero quotient and remainder. It performs one unsigned radix-2 non-restoring step per clock, followed by a sign-fix cycle. Results are registered behind a start/busy/done handshake so that it can sit beside the multiplier in the arithmetic unit.

---
 rtl/booth_div_signed_iter.sv | 171 +++++++++++++++++
 tb/tb_booth_div_signed_iter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_div_signed_iter.sv
// booth_div_signed_iter
// Iterative signed integer divider. The quotient is truncated toward zero and
// the remainder takes the sign of the dividend. Each clock performs one
// unsigned radix-2 non-restoring step on operand magnitudes. A final cycle then
// corrects the remainder and applies the result signs.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request a division (sampled in IDLE or DONE only)
//   A, B   : signed dividend / divisor, captured on the accepting edge
//   busy   : high while the operation is in CALC or FIX
//   done   : one-cycle pulse when Q/R have just been updated
//   Q, R   : signed quotient / remainder, held until the next done
//
// width must be even and >= 4. Latency is width+2 cycles from the accepting
// edge to done, for every operand value.
module booth_div_signed_iter #(
    parameter int width = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width:1]   A,
    input  logic [width:1]   B,
    output logic             busy,
    output logic             done,
    output logic [width:1]   Q,
    output logic [width:1]   R
);

    localparam int CW = $clog2(width);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    count_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             b_zero_reg;
    logic [width-1:0] a_raw_reg;
    // Divisor magnitude. One extra bit keeps the add/subtract in the
    // partial-remainder width and holds |-2^(width-1)| without wrapping.
    logic [width:0]   b_mag_reg;
    // Shifts dividend magnitude bits out of the top and quotient bits into the
    // bottom. After width steps it holds the quotient magnitude.
    logic [width-1:0] dq_reg;
    // Partial remainder in two's complement; bit width+1 is its sign.
    logic [width+1:0] pr_reg;
    logic [width-1:0] q_reg;
    logic [width-1:0] r_reg;

    logic             accept;
    logic [width-1:0] a_in;
    logic [width-1:0] b_in;
    // Magnitudes read as unsigned width-bit values. Under that reading,
    // -(-2^(width-1)) gives 2^(width-1), which is correct.
    logic [width-1:0] a_mag;
    logic [width-1:0] b_mag;
    logic [width+1:0] b_ext;
    logic [width+1:0] pr_sh;
    logic [width+1:0] pr_step;
    logic             q_bit;
    logic [width-1:0] r_low;
    logic [width-1:0] q_fix;
    logic [width-1:0] r_fix;

    assign a_in   = A;
    assign b_in   = B;
    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign busy   = (state_reg == CALC) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign Q      = q_reg;
    assign R      = r_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = CALC;
            CALC: if (count_reg == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath combinational terms
    // ------------------------------------------------------------------
    always_comb begin
        a_mag   = a_in[width-1] ? -a_in : a_in;
        b_mag   = b_in[width-1] ? -b_in : b_in;
        b_ext   = {1'b0, b_mag_reg};
        // Shift {partial remainder, dividend magnitude} left by one.
        pr_sh   = {pr_reg[width:0], dq_reg[width-1]};
        // Non-restoring step. A negative remainder is corrected on the next
        // step by adding instead of subtracting.
        pr_step = pr_reg[width+1] ? (pr_sh + b_ext) : (pr_sh - b_ext);
        q_bit   = ~pr_step[width+1];
        // The remainder magnitude is below |B|, so only its low width bits
        // are needed. Adding back |B| modulo 2^width is enough.
        r_low   = pr_reg[width-1:0] + (pr_reg[width+1] ? b_mag_reg[width-1:0] : '0);
        q_fix   = (sign_a_reg ^ sign_b_reg) ? -dq_reg : dq_reg;
        r_fix   = sign_a_reg ? -r_low : r_low;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            a_raw_reg  <= '0;
            b_mag_reg  <= '0;
            dq_reg     <= '0;
            pr_reg     <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
        end else if (accept) begin
            count_reg  <= CW'(width - 1);
            sign_a_reg <= a_in[width-1];
            sign_b_reg <= b_in[width-1];
            b_zero_reg <= (b_in == '0);
            a_raw_reg  <= a_in;
            b_mag_reg  <= {1'b0, b_mag};
            dq_reg     <= a_mag;
            pr_reg     <= '0;
        end else if (state_reg == CALC) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - CW'(1);
            end
            pr_reg <= pr_step;
            dq_reg <= {dq_reg[width-2:0], q_bit};
        end else if (state_reg == FIX) begin
            if (b_zero_reg) begin
                // Division by zero yields Q = -1 and R = dividend.
                q_reg <= '1;
                r_reg <= a_raw_reg;
            end else begin
                // -2^(width-1) / -1 wraps back to -2^(width-1) because the
                // result is truncated to width bits.
                q_reg <= q_fix;
                r_reg <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_booth_div_signed_iter.sv
module tb_booth_div_signed_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start10 = 1'b0;
    logic [10:1] a10 = '0, b10 = '0;
    logic [10:1] q10, r10;
    logic        busy10, done10;

    logic        start16 = 1'b0;
    logic [16:1] a16 = '0, b16 = '0;
    logic [16:1] q16, r16;
    logic        busy16, done16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_div_signed_iter #(.width(10)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .A(a10), .B(b10),
        .busy(busy10), .done(done10), .Q(q10), .R(r10)
    );

    booth_div_signed_iter #(.width(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .Q(q16), .R(r16)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Truncating signed division, with the divide-by-zero and overflow rules.
    task automatic ref_div(input int w, input int a, input int b,
                           output int q, output int r);
        if (b == 0) begin
            q = -1;
            r = a;
        end else if (a == -(1 << (w - 1)) && b == -1) begin
            q = a;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic logic cur_done(input int w);
        return (w == 10) ? done10 : done16;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 10) ? busy10 : busy16;
    endfunction

    function automatic logic signed [31:0] obs_q(input int w);
        logic signed [31:0] v;
        if (w == 10) v = 32'($signed(q10));
        else         v = 32'($signed(q16));
        return v;
    endfunction

    function automatic logic signed [31:0] obs_r(input int w);
        logic signed [31:0] v;
        if (w == 10) v = 32'($signed(r10));
        else         v = 32'($signed(r16));
        return v;
    endfunction

    task automatic set_start(input int w, input logic s);
        if (w == 10) start10 = s;
        else         start16 = s;
    endtask

    task automatic set_ops(input int w, input int a, input int b);
        if (w == 10) begin a10 = a[9:0];  b10 = b[9:0];  end
        else         begin a16 = a[15:0]; b16 = b[15:0]; end
    endtask

    // Drive start for one edge. Afterwards we sit in cycle 1 of the operation.
    task automatic launch(input int w, input int a, input int b);
        @(posedge clk); #1;
        set_ops(w, a, b);
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        // Operands must not matter after the accepting edge.
        set_ops(w, int'($urandom), int'($urandom));
    endtask

    // Wait for done. Check latency, busy, held outputs and the result.
    // pulse_at > 0 re-asserts start with other operands in that busy cycle.
    // Returns in the done cycle.
    task automatic finish_op(input int w, input int a, input int b, input int pulse_at);
        int eq, er, n;
        int busy_ok, hold_ok;
        logic signed [31:0] pq, pr, qs, rs;
        ref_div(w, a, b, eq, er);
        pq = obs_q(w);
        pr = obs_r(w);
        n = 1;
        busy_ok = 1;
        hold_ok = 1;
        while (cur_done(w) !== 1'b1 && n < 40) begin
            if (cur_busy(w) !== 1'b1) busy_ok = 0;
            if (obs_q(w) !== pq || obs_r(w) !== pr) hold_ok = 0;
            if (n == pulse_at) begin
                set_ops(w, -3, 5);
                set_start(w, 1'b1);
            end else begin
                set_start(w, 1'b0);
            end
            @(posedge clk); #1;
            n++;
        end
        set_start(w, 1'b0);
        chk("latency", n, w + 2);
        chk("busy_during", busy_ok, 1);
        chk("qr_held", hold_ok, 1);
        chk("busy_at_done", 32'(cur_busy(w)), 0);
        qs = obs_q(w);
        rs = obs_r(w);
        chk("Q", qs, eq);
        chk("R", rs, er);
        if (b != 0 && !(a == -(1 << (w - 1)) && b == -1)) begin
            chk("invariant", a, qs * b + rs);
            chk("rem_mag", (iabs(int'(rs)) < iabs(b)) ? 1 : 0, 1);
            chk("rem_sign", (rs == 0 || ((rs < 0) == (a < 0))) ? 1 : 0, 1);
        end
        $display("op w=%0d A=%0d B=%0d Q=%0d R=%0d exp_Q=%0d exp_R=%0d lat=%0d",
                 w, a, b, qs, rs, eq, er, n);
    endtask

    task automatic do_op(input int w, input int a, input int b);
        launch(w, a, b);
        finish_op(w, a, b, 0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(cur_done(w)), 0);
    endtask

    initial begin
        int a, b, seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy10", 32'(busy10), 0);
        chk("rst_done10", 32'(done10), 0);
        chk("rst_q10", 32'(q10), 0);
        chk("rst_r10", 32'(r10), 0);
        chk("rst_busy16", 32'(busy16), 0);
        chk("rst_q16", 32'(q16), 0);
        rst = 1'b0;

        // Sign combinations
        do_op(10, 100, 7);
        do_op(10, -100, 7);
        chk("neg_q_raw", 32'(q10), 32'h3F2);
        chk("neg_r_raw", 32'(r10), 32'h3FE);
        do_op(10, 100, -7);
        do_op(10, -100, -7);

        // Edge operands
        do_op(10, -512, -1);
        chk("ovf_q_raw", 32'(q10), 32'h200);
        chk("ovf_r_raw", 32'(r10), 0);
        do_op(10, -512, 1);
        chk("min_div1_raw", 32'(q10), 32'h200);
        do_op(10, 511, -512);
        do_op(10, 3, 5);

        // Divide by zero
        do_op(10, 37, 0);
        chk("dz_q_raw", 32'(q10), 32'h3FF);
        do_op(10, -5, 0);
        chk("dz_r_raw", 32'(r10), 32'h3FB);

        // start during busy is ignored; start in the done cycle chains
        launch(10, 200, 9);
        finish_op(10, 200, 9, 4);
        set_ops(10, -77, 6);
        start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        chk("b2b_busy", 32'(busy10), 1);
        finish_op(10, -77, 6, 0);
        @(posedge clk); #1;
        chk("b2b_done_pulse", 32'(done10), 0);

        // Reset in cycle 6 of CALC
        launch(10, 123, -11);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy10), 0);
        chk("mid_rst_done", 32'(done10), 0);
        chk("mid_rst_q", 32'(q10), 0);
        chk("mid_rst_r", 32'(r10), 0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done10 !== 1'b0 || busy10 !== 1'b0) seen = 1;
        end
        chk("no_done_after_rst", seen, 0);
        do_op(10, 123, -11);

        // Random operands
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 1023)) - 512;
            if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 6)) - 3;
            else                           b = int'($urandom_range(0, 1023)) - 512;
            do_op(10, a, b);
        end
        do_op(16, -32768, -1);
        do_op(16, 12345, 0);
        for (int i = 0; i < 1000; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 20)) - 10;
            else                           b = int'($urandom_range(0, 65535)) - 32768;
            do_op(16, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
